// File: rtl/branch_ckpt_ctrl.sv
// branch_ckpt_ctrl: circular FIFO of branch checkpoints with in-order retire
// and single-cycle mispredict recovery (restore + flush pulse).
`default_nettype none

module branch_ckpt_ctrl #(
  parameter int NUM_CKPT   = 4,
  parameter int CKPT_WIDTH = 2,
  parameter int ROB_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br_dispatch_valid,
  input  logic [ROB_WIDTH-1:0]  br_rob_tag,
  output logic                  ckpt_ready,
  output logic                  ckpt_save,
  output logic [CKPT_WIDTH-1:0] ckpt_save_id,
  input  logic                  resolve_valid,
  input  logic [CKPT_WIDTH-1:0] resolve_id,
  input  logic                  resolve_mispredict,
  output logic                  ckpt_free,
  output logic [CKPT_WIDTH-1:0] ckpt_free_id,
  output logic                  restore_valid,
  output logic [CKPT_WIDTH-1:0] restore_id,
  output logic [ROB_WIDTH-1:0]  restore_rob_tag,
  output logic                  flush,
  output logic [CKPT_WIDTH:0]   ckpt_count
);

  typedef enum logic [0:0] {NORMAL = 1'b0, RECOVER = 1'b1} state_t;

  localparam logic [CKPT_WIDTH:0] FULL_COUNT = (CKPT_WIDTH+1)'(NUM_CKPT);

  state_t                  state_q, state_d;
  logic [CKPT_WIDTH-1:0]   head_q, head_d;
  logic [CKPT_WIDTH-1:0]   tail_q, tail_d;
  logic [CKPT_WIDTH:0]     count_q, count_d;
  logic [NUM_CKPT-1:0]     valid_q, valid_d;
  logic [NUM_CKPT-1:0]     resolved_q, resolved_d;
  logic                    free_q, free_d;
  logic [CKPT_WIDTH-1:0]   free_id_q, free_id_d;
  logic [CKPT_WIDTH-1:0]   restore_id_q, restore_id_d;
  logic [ROB_WIDTH-1:0]    restore_tag_q, restore_tag_d;
  logic [ROB_WIDTH-1:0]    tag_q [NUM_CKPT];

  logic                    mispredict;
  logic                    resolve_ok;
  logic                    retire_fire;
  logic [CKPT_WIDTH-1:0]   rel;

  assign ckpt_ready = (state_q == NORMAL) && (count_q < FULL_COUNT) && reset;
  assign ckpt_save  = br_dispatch_valid && ckpt_ready && !(resolve_valid && resolve_mispredict);
  assign ckpt_save_id = tail_q;

  assign mispredict = resolve_valid && resolve_mispredict && valid_q[resolve_id] && (state_q == NORMAL);
  assign resolve_ok = resolve_valid && !resolve_mispredict && valid_q[resolve_id] && (state_q == NORMAL);
  assign rel        = resolve_id - head_q;
  // Head cannot retire when the mispredicting branch is the head itself.
  assign retire_fire = valid_q[head_q] && resolved_q[head_q] && !(mispredict && (resolve_id == head_q));

  assign ckpt_free       = free_q;
  assign ckpt_free_id    = free_id_q;
  assign restore_valid   = (state_q == RECOVER);
  assign flush           = (state_q == RECOVER);
  assign restore_id      = restore_id_q;
  assign restore_rob_tag = restore_tag_q;
  assign ckpt_count      = count_q;

  always_comb begin
    state_d       = NORMAL;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    valid_d       = valid_q;
    resolved_d    = resolved_q;
    free_d        = 1'b0;
    free_id_d     = head_q;
    restore_id_d  = restore_id_q;
    restore_tag_d = restore_tag_q;

    if (resolve_ok) begin
      resolved_d[resolve_id] = 1'b1;
    end

    if (retire_fire) begin
      valid_d[head_q]    = 1'b0;
      resolved_d[head_q] = 1'b0;
      head_d             = head_q + 1'b1;
      free_d             = 1'b1;
    end

    if (mispredict) begin
      state_d       = RECOVER;
      tail_d        = resolve_id;
      restore_id_d  = resolve_id;
      restore_tag_d = tag_q[resolve_id];
      count_d       = {1'b0, rel} - (CKPT_WIDTH+1)'(retire_fire);
      // Slots at or beyond the mispredicting branch in program order are squashed.
      for (int i = 0; i < NUM_CKPT; i++) begin
        if (CKPT_WIDTH'(CKPT_WIDTH'(i) - head_q) >= rel) begin
          valid_d[i]    = 1'b0;
          resolved_d[i] = 1'b0;
        end
      end
    end else begin
      count_d = count_q + (CKPT_WIDTH+1)'(ckpt_save) - (CKPT_WIDTH+1)'(retire_fire);
    end

    if (ckpt_save) begin
      valid_d[tail_q]    = 1'b1;
      resolved_d[tail_q] = 1'b0;
      tail_d             = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= NORMAL;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      valid_q       <= '0;
      resolved_q    <= '0;
      free_q        <= 1'b0;
      free_id_q     <= '0;
      restore_id_q  <= '0;
      restore_tag_q <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      resolved_q    <= resolved_d;
      free_q        <= free_d;
      free_id_q     <= free_id_d;
      restore_id_q  <= restore_id_d;
      restore_tag_q <= restore_tag_d;
    end
  end

  // Snapshot payload needs no reset; it is only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (ckpt_save) begin
      tag_q[tail_q] <= br_rob_tag;
    end
  end

endmodule

`default_nettype wire

// File: doc/branch_ckpt_ctrl.md
BRANCH_CKPT_CTRL -- requirements
Module: branch_ckpt_ctrl

Interface
REQ-001 SHALL take parameter NUM_CKPT, default 4; number of branch checkpoint slots (power of two).
REQ-002 SHALL take parameter CKPT_WIDTH, default 2; equal to log2(NUM_CKPT).
REQ-003 SHALL take parameter ROB_WIDTH, default 4; ROB tag width.
REQ-004 SHALL have port clk, input, 1; the single clock, with all state updated on its rising edge.
REQ-005 SHALL have port reset, input, 1; synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port br_dispatch_valid, input, 1; a branch is dispatching this cycle.
REQ-007 SHALL have port br_rob_tag, input, ROB_WIDTH; the ROB tag of the dispatching branch.
REQ-008 SHALL have port ckpt_ready, output, 1; a slot is free and no recovery is in progress (stall to rename when low).
REQ-009 SHALL have port ckpt_save, output, 1; snapshot pulse to the map table, free list and ROB allocator.
REQ-010 SHALL have port ckpt_save_id, output, CKPT_WIDTH; the slot ID being allocated.
REQ-011 SHALL have port resolve_valid, input, 1; a branch resolved this cycle.
REQ-012 SHALL have port resolve_id, input, CKPT_WIDTH; the checkpoint ID of the resolving branch.
REQ-013 SHALL have port resolve_mispredict, input, 1; the resolving branch mispredicted.
REQ-014 SHALL have port ckpt_free, output, 1; pulse indicating the oldest checkpoint retired.
REQ-015 SHALL have port ckpt_free_id, output, CKPT_WIDTH; the ID of the retired checkpoint.
REQ-016 SHALL have port restore_valid, output, 1; pulse to restore snapshot restore_id.
REQ-017 SHALL have port restore_id, output, CKPT_WIDTH; the checkpoint to restore.
REQ-018 SHALL have port restore_rob_tag, output, ROB_WIDTH; the saved br_rob_tag of restore_id.
REQ-019 SHALL have port flush, output, 1; flush of younger-than-branch front-end state.
REQ-020 SHALL have port ckpt_count, output, CKPT_WIDTH+1; the number of occupied slots.

Function
REQ-021 SHALL manage slots as a circular FIFO in program order using head (oldest), tail (next alloc) and count registers, with pointers wrapping modulo NUM_CKPT.
REQ-022 SHALL implement states NORMAL and RECOVER, entering NORMAL on reset.
REQ-023 SHALL drive ckpt_ready = (state==NORMAL) && (count<NUM_CKPT) && reset, combinationally.
REQ-024 SHALL assert ckpt_save = br_dispatch_valid && ckpt_ready && !(resolve_valid && resolve_mispredict), with ckpt_save_id=tail, in the same cycle (combinational).
REQ-025 On ckpt_save, SHALL store br_rob_tag and set valid[tail]=1 and resolved[tail]=0, then advance tail by 1 and count by 1 at the clock edge.
REQ-026 On resolve_valid && !resolve_mispredict with valid[resolve_id]=1, SHALL set resolved[resolve_id]=1 at the clock edge.
REQ-027 SHALL retire at most one slot per cycle: when valid[head] && resolved[head], assert registered ckpt_free=1 with ckpt_free_id=head, then clear valid[head], advance head and decrement count.
REQ-028 On resolve_valid && resolve_mispredict with valid[resolve_id]=1 in NORMAL, SHALL go to RECOVER, set tail=resolve_id, clear valid for resolve_id and every younger slot, and set count=(resolve_id-head) mod NUM_CKPT.
REQ-029 In the cycle after the mispredict (the RECOVER cycle), SHALL assert restore_valid=1 and flush=1 with registered restore_id and restore_rob_tag; the latency is exactly 1 cycle from the mispredict input.
REQ-030 SHALL hold RECOVER for exactly one cycle and then return to NORMAL, with ckpt_ready=0 throughout RECOVER.
REQ-031 SHALL ignore resolves in RECOVER and resolves targeting an invalid slot.
REQ-032 SHALL keep count consistent under simultaneous save, retire and resolve-correct in one cycle (net count = count + save - retire).
REQ-033 When full, a slot freed by retirement SHALL become available the following cycle (no same-cycle bypass).
REQ-034 When a retire of head and a mispredict coincide, the mispredict SHALL take priority for tail/valid updates and the retire SHALL still complete if head is older than resolve_id.
REQ-035 SHALL compute all pointer arithmetic in CKPT_WIDTH bits, wrapping naturally.

Reset
REQ-036 While reset=0 at an edge, SHALL set head=tail=0, count=0, all valid/resolved bits=0, state=NORMAL, and ckpt_save=ckpt_free=restore_valid=flush=0; ckpt_ready SHALL be 0 while reset=0.
REQ-037 Reset asserted during RECOVER SHALL abort recovery with no restore_valid pulse afterward.

Verification
REQ-038 Reset, then 4 consecutive branch dispatches -> ckpt_save_id 0,1,2,3; ckpt_count=4; ckpt_ready=0; 5th dispatch produces no ckpt_save.
REQ-039 Full buffer, resolve IDs 1 and then 0 correct -> ckpt_free id0 and then id1 on consecutive cycles; ckpt_count=2.
REQ-040 With IDs 0..2 outstanding, mispredict on ID 1 (rob tag 5) -> next cycle restore_valid=1, restore_id=1, restore_rob_tag=5, flush=1; ckpt_count=1; next save_id=1.
REQ-041 Mispredict coinciding with br_dispatch_valid -> ckpt_save=0 and tail unchanged by the dispatch.
REQ-042 Wrap-around: head=3 and tail=1 (count 2), mispredict on ID 0 -> count=1, tail=0.
REQ-043 Reset=0 in the RECOVER cycle -> all outputs at reset values on the next cycle; ckpt_count=0.
